rom_read_sequencer: RTL

Sequential read controller placed directly upstream of the team's 8x16 combinational ROM (cs/addrb/datab/read_en interface). On a start command it walks a run of consecutive ROM addresses and drives cs, read_en and addrb for each word. It captures each returned datab word into a 2-entry skid buffer and presents the words to a downstream consumer over a valid/ready handshake. It stalls ROM reads under backpressure, so no word is lost or duplicated.

---
 rtl/rom_read_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rom_read_sequencer.sv
// Sequential read controller for a combinational ROM. It walks a run of consecutive
// addresses and delivers the returned words through a 2-entry skid buffer over valid/ready.
module rom_read_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_count,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_cs,
   output logic              o_read_en,
   output logic [ADDR_W-1:0] o_addrb,
   input  logic [DATA_W-1:0] i_datab,
   output logic [DATA_W-1:0] o_out_data,
   output logic [ADDR_W-1:0] o_out_addr,
   output logic              o_out_valid,
   input  logic              i_out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cur;
   logic [ADDR_W-1:0]   r_last_addr;
   logic [CNT_W-1:0]    r_rem;
   logic                r_done;
   logic                w_done_nxt;

   logic [DATA_W-1:0]   r_buf_data [2];
   logic [ADDR_W-1:0]   r_buf_addr [2];
   logic                r_rd_ptr;
   logic                r_wr_ptr;
   logic [1:0]          r_occ;

   logic                w_pop;
   logic                w_space;
   logic                w_issue;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_addrb;

   // A same-cycle pop frees a slot, so out_ready reaches cs combinationally on purpose.
   assign w_pop   = (r_occ != 2'd0) && i_out_ready;
   assign w_space = (r_occ < 2'd2) || w_pop;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      w_addrb     = r_last_addr;
      case (r_state)
         ST_IDLE: begin
            w_addrb = '0;
            if (i_start) begin
               if (i_count != '0) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_READ;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         ST_READ: begin
            w_issue = (r_rem != '0) && w_space;
            if (w_issue) begin
               w_addrb = r_cur;
               if (r_rem == CNT_W'(1)) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pop && (r_occ == 2'd1)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_done      <= 1'b0;
         r_cur       <= '0;
         r_rem       <= '0;
         r_last_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_cur <= i_base_addr;
            r_rem <= i_count;
         end else if (w_issue) begin
            r_cur       <= r_cur + ADDR_W'(1);
            r_rem       <= r_rem - CNT_W'(1);
            r_last_addr <= r_cur;
         end
      end
   end

   // NOTE: the two buffer entries are reset as well, because out_data/out_addr must read
   // zero after reset; a deeper storage array would normally be left unreset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_buf_data[i] <= '0;
            r_buf_addr[i] <= '0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_issue) begin
            r_buf_data[r_wr_ptr] <= i_datab;
            r_buf_addr[r_wr_ptr] <= r_cur;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_issue, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = r_done;
   assign o_cs        = w_issue;
   assign o_read_en   = w_issue;
   assign o_addrb     = w_addrb;
   assign o_out_valid = (r_occ != 2'd0);
   assign o_out_data  = r_buf_data[r_rd_ptr];
   assign o_out_addr  = r_buf_addr[r_rd_ptr];

endmodule
